// File: rtl/shot_pkg.sv
// Shared types for the shot scheduler: slot record, controller states, spawn helper.
package shot_pkg;

   localparam int c_DefNumShots = 4;
   localparam int c_DefSlotW    = $clog2(c_DefNumShots);

   typedef logic [c_DefSlotW-1:0] slot_idx_t;

   typedef struct packed {
      logic       active;
      logic [5:0] row;
      logic [5:0] col;
   } shot_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ARMED    = 2'd1,
      COOLDOWN = 2'd2
   } state_e;

   // Column wraps modulo 64 like the rest of the board arithmetic.
   function automatic logic [5:0] spawn_col(input logic [5:0] paddle_y, input int height);
      return paddle_y + 6'(height / 2);
   endfunction

endpackage

// File: rtl/shot_slot_alloc.sv
// Lowest-set-bit priority encoder; used for free-slot allocation and for the draw match.
module shot_slot_alloc #(
   parameter  int c_N = 4,
   localparam int c_W = $clog2(c_N)
) (
   input  logic [c_N-1:0] i_Mask,
   output logic           o_Valid,
   output logic [c_W-1:0] o_Idx
);

   // Scan from the top so the lowest set index is the last one written.
   always_comb begin
      o_Valid = 1'b0;
      o_Idx   = '0;
      for (int i = c_N - 1; i >= 0; i--) begin
         o_Valid = o_Valid | i_Mask[i];
         o_Idx   = i_Mask[i] ? c_W'(i) : o_Idx;
      end
   end

endmodule

// File: rtl/shot_sched.sv
// Projectile scheduler: fire acceptance, slot allocation, shot movement and draw match.
// Build option: SHOT_AUTOFIRE_EN makes the fire event the i_Fire level instead of its rising edge.
module shot_sched
   import shot_pkg::*;
#(
   parameter int c_NumShots     = c_DefNumShots,
   parameter int c_PaddleRow    = 29,
   parameter int c_PaddleHeight = 4,
   parameter int c_ShotSpeed    = 625000,
   parameter int c_Cooldown     = 2500000
) (
   input  logic                          i_Clk,
   input  logic                          i_Rst_L,
   input  logic                          i_Game_Active,
   input  logic                          i_Fire,
   input  logic [5:0]                    i_PaddleY,
   input  logic                          i_Hit_Valid,
   input  logic [$clog2(c_NumShots)-1:0] i_Hit_Slot,
   input  logic [5:0]                    i_ColCountDiv,
   input  logic [5:0]                    i_RowCountDiv,
   output logic                          o_DrawShot,
   output logic [$clog2(c_NumShots)-1:0] o_ShotSlot,
   output logic                          o_Fired,
   output logic [c_NumShots-1:0]         o_ActiveMask
);

   localparam int c_SW = $clog2(c_NumShots);
   localparam int c_TW = $clog2(c_ShotSpeed + 1);
   localparam int c_CW = $clog2(c_Cooldown + 1);

   state_e            state_q, state_d;
   logic [c_CW-1:0]   cd_q, cd_d;
   logic [c_TW-1:0]   tick_q, tick_d;
   logic              fire_prev_q, fire_prev_d;
   shot_t             slot_q [c_NumShots];
   shot_t             slot_d [c_NumShots];
   logic              fired_q, fired_d;
   logic              draw_q, draw_d;
   logic [c_SW-1:0]   draw_slot_q, draw_slot_d;

   logic [c_NumShots-1:0] active_mask_s, free_mask_s, match_mask_s;
   logic                  alloc_valid_s, match_valid_s;
   logic [c_SW-1:0]       alloc_idx_s, match_idx_s;
   logic                  tick_s, fire_evt_s, accept_s;

   // Per-slot views of the registered pool.
   always_comb begin
      active_mask_s = '0;
      free_mask_s   = '0;
      match_mask_s  = '0;
      for (int i = 0; i < c_NumShots; i++) begin
         active_mask_s[i] = slot_q[i].active;
         free_mask_s[i]   = ~slot_q[i].active;
         match_mask_s[i]  = slot_q[i].active && (slot_q[i].row == i_RowCountDiv)
                            && (slot_q[i].col == i_ColCountDiv);
      end
   end

   shot_slot_alloc #(.c_N(c_NumShots)) u_alloc (
      .i_Mask (free_mask_s),
      .o_Valid(alloc_valid_s),
      .o_Idx  (alloc_idx_s)
   );

   shot_slot_alloc #(.c_N(c_NumShots)) u_match (
      .i_Mask (match_mask_s),
      .o_Valid(match_valid_s),
      .o_Idx  (match_idx_s)
   );

   // Fire event, move tick and acceptance decision.
   always_comb begin
      fire_prev_d = i_Fire;
`ifdef SHOT_AUTOFIRE_EN
      fire_evt_s  = i_Fire;
`else
      fire_evt_s  = i_Fire & ~fire_prev_q;
`endif
      tick_s   = (state_q != IDLE) && (tick_q == c_TW'(c_ShotSpeed - 1));
      accept_s = i_Game_Active && (state_q == ARMED) && fire_evt_s && alloc_valid_s;
   end

   // Controller next state; losing game-active overrides every other transition.
   always_comb begin
      state_d = state_q;
      cd_d    = cd_q;
      if (!i_Game_Active) begin
         state_d = IDLE;
         cd_d    = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = ARMED;
               cd_d    = '0;
            end
            ARMED: begin
               if (accept_s) begin
                  state_d = COOLDOWN;
                  cd_d    = c_CW'(c_Cooldown - 1);
               end else begin
                  state_d = ARMED;
               end
            end
            COOLDOWN: begin
               if (cd_q == '0) begin
                  state_d = ARMED;
               end else begin
                  cd_d = cd_q - c_CW'(1);
               end
            end
            default: begin
               state_d = IDLE;
               cd_d    = '0;
            end
         endcase
      end
   end

   // Free-running move-rate counter, parked at zero while idle.
   always_comb begin
      tick_d = tick_q;
      if (!i_Game_Active || (state_q == IDLE)) begin
         tick_d = '0;
      end else if (tick_s) begin
         tick_d = '0;
      end else begin
         tick_d = tick_q + c_TW'(1);
      end
   end

   // Slot update: flush, then hit, then tick move; allocation only into slots free at cycle start.
   always_comb begin
      for (int i = 0; i < c_NumShots; i++) begin
         slot_d[i] = slot_q[i];
         if (!i_Game_Active) begin
            slot_d[i] = '0;
         end else if (slot_q[i].active) begin
            if (i_Hit_Valid && (i_Hit_Slot == c_SW'(i))) begin
               slot_d[i] = '0;
            end else if (tick_s) begin
               if (slot_q[i].row == 6'd0) begin
                  slot_d[i] = '0;
               end else begin
                  slot_d[i].row = slot_q[i].row - 6'd1;
               end
            end else begin
               slot_d[i] = slot_q[i];
            end
         end else if (accept_s && (alloc_idx_s == c_SW'(i))) begin
            slot_d[i].active = 1'b1;
            slot_d[i].row    = 6'(c_PaddleRow - 1);
            slot_d[i].col    = spawn_col(i_PaddleY, c_PaddleHeight);
         end else begin
            slot_d[i] = slot_q[i];
         end
      end
   end

   // Output staging; draw is blanked on the cycle play stops.
   always_comb begin
      fired_d     = accept_s;
      draw_d      = i_Game_Active & match_valid_s;
      draw_slot_d = i_Game_Active ? match_idx_s : '0;
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge i_Clk) begin
      if (!i_Rst_L) begin
         state_q     <= IDLE;
         cd_q        <= '0;
         tick_q      <= '0;
         fire_prev_q <= 1'b0;
         fired_q     <= 1'b0;
         draw_q      <= 1'b0;
         draw_slot_q <= '0;
         for (int i = 0; i < c_NumShots; i++) begin
            slot_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         cd_q        <= cd_d;
         tick_q      <= tick_d;
         fire_prev_q <= fire_prev_d;
         fired_q     <= fired_d;
         draw_q      <= draw_d;
         draw_slot_q <= draw_slot_d;
         for (int i = 0; i < c_NumShots; i++) begin
            slot_q[i] <= slot_d[i];
         end
      end
   end

   assign o_Fired      = fired_q;
   assign o_ActiveMask = active_mask_s;
   assign o_DrawShot   = draw_q;
   assign o_ShotSlot   = draw_slot_q;

endmodule

// File: tb/tb_shot_sched.sv
// Bench for shot_sched: directed scenarios plus random traffic against a cycle-indexed reference model.
module tb_shot_sched;

   localparam int NS   = 4;
   localparam int PROW = 29;
   localparam int PH   = 4;
   localparam int SPD  = 12;
   localparam int CD   = 10;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0, game = 1'b0, fire = 1'b0, hit_v = 1'b0;
   logic [1:0] hit_slot = 2'd0;
   logic [5:0] py = 6'd10, scan_row = 6'd0, scan_col = 6'd0;

   logic       o_draw, o_fired;
   logic [1:0] o_slot;
   logic [3:0] o_mask;

   shot_sched #(.c_NumShots(NS), .c_PaddleRow(PROW), .c_PaddleHeight(PH),
                .c_ShotSpeed(SPD), .c_Cooldown(CD)) dut (
      .i_Clk(clk), .i_Rst_L(rst_n), .i_Game_Active(game), .i_Fire(fire),
      .i_PaddleY(py), .i_Hit_Valid(hit_v), .i_Hit_Slot(hit_slot),
      .i_ColCountDiv(scan_col), .i_RowCountDiv(scan_row),
      .o_DrawShot(o_draw), .o_ShotSlot(o_slot), .o_Fired(o_fired), .o_ActiveMask(o_mask)
   );

   always #5 clk = ~clk;

   int n_checks = 0, n_errors = 0;

   // Reference model: m_run = index of the next edge within the current active run.
   bit   m_act [NS];
   int   m_row [NS];
   int   m_col [NS];
   int   m_run = 0, m_last_acc = 0;
   bit   m_has_acc = 0, m_prev = 0;
   logic e_fired = 1'b0, e_draw = 1'b0;
   logic [1:0] e_slot = 2'd0;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] model_mask();
      logic [3:0] m = 4'd0;
      for (int i = 0; i < NS; i++) m[i] = m_act[i];
      return m;
   endfunction

   task automatic clear_model();
      for (int i = 0; i < NS; i++) begin
         m_act[i] = 1'b0; m_row[i] = 0; m_col[i] = 0;
      end
      m_run = 0; m_has_acc = 1'b0;
   endtask

   // One clock: predict, advance the model across the edge, compare all outputs.
   task automatic cyc();
      bit armed, tick, evt;
      int free_idx;
      e_draw = 1'b0; e_slot = 2'd0;
      for (int i = NS - 1; i >= 0; i--)
         if (m_act[i] && m_row[i] == int'(scan_row) && m_col[i] == int'(scan_col)) begin
            e_draw = 1'b1; e_slot = 2'(i);
         end
      @(posedge clk);
      e_fired = 1'b0;
      if (!rst_n) begin
         clear_model();
         e_draw = 1'b0; e_slot = 2'd0; m_prev = 1'b0;
      end else begin
         if (!game) begin
            clear_model();
            e_draw = 1'b0; e_slot = 2'd0;
         end else begin
            armed = (m_run >= 1) && (!m_has_acc || (m_run - m_last_acc) >= CD + 1);
            tick  = (m_run > 0) && (m_run % SPD == 0);
`ifdef SHOT_AUTOFIRE_EN
            evt   = fire;
`else
            evt   = fire && !m_prev;
`endif
            free_idx = -1;
            for (int i = NS - 1; i >= 0; i--) if (!m_act[i]) free_idx = i;
            for (int i = 0; i < NS; i++) begin
               if (m_act[i]) begin
                  if (hit_v && int'(hit_slot) == i) m_act[i] = 1'b0;
                  else if (tick) begin
                     if (m_row[i] == 0) m_act[i] = 1'b0;
                     else m_row[i] = m_row[i] - 1;
                  end
               end
            end
            if (armed && evt && free_idx >= 0) begin
               m_act[free_idx] = 1'b1;
               m_row[free_idx] = PROW - 1;
               m_col[free_idx] = (int'(py) + PH / 2) % 64;
               e_fired = 1'b1; m_has_acc = 1'b1; m_last_acc = m_run;
            end
            m_run++;
         end
         m_prev = fire;
      end
      #1;
      chk("fired", {7'd0, o_fired}, {7'd0, e_fired});
      chk("mask",  {4'd0, o_mask},  {4'd0, model_mask()});
      chk("draw",  {7'd0, o_draw},  {7'd0, e_draw});
      chk("slot",  {6'd0, o_slot},  {6'd0, e_slot});
   endtask

   // Half the time aim the scan at a live shot so the draw path sees real matches.
   task automatic pick_scan();
      int j = $urandom_range(0, NS - 1);
      if ($urandom_range(0, 1) == 1 && m_act[j]) begin
         scan_row = 6'(m_row[j]); scan_col = 6'(m_col[j]);
      end else begin
         scan_row = 6'($urandom); scan_col = 6'($urandom);
      end
   endtask

   task automatic quiet();
      fire = 1'b0; hit_v = 1'b0; pick_scan();
   endtask

   task automatic run_until(input int target);
      for (int k = 0; k < 2000 && m_run != target; k++) begin
         quiet(); cyc();
      end
      chk("run_reached", 8'(m_run == target), 8'd1);
   endtask

   task automatic fire_now();
      hit_v = 1'b0; fire = 1'b1; pick_scan(); cyc(); fire = 1'b0;
   endtask

   initial begin
      // Reset state
      rst_n = 1'b0; game = 1'b0; quiet(); cyc(); cyc();
      chk("rst_mask", {4'd0, o_mask}, 8'd0);
      chk("rst_draw", {7'd0, o_draw}, 8'd0);
      rst_n = 1'b1; game = 1'b1; py = 6'd10;

      // First shot: slot 0 at row 28, column 12
      quiet(); cyc();
      fire_now();
      chk("first_fired", {7'd0, o_fired}, 8'd1);
      chk("first_mask", {4'd0, o_mask}, 8'h01);
      quiet(); scan_row = 6'd28; scan_col = 6'd12; cyc();
      chk("first_draw", {7'd0, o_draw}, 8'd1);
      chk("first_slot", {6'd0, o_slot}, 8'd0);

      // Fire edges every 3 clocks: cooldown filters them, pool fills, extra fire dropped
      for (int i = 0; i < 60; i++) begin
         hit_v = 1'b0; fire = (i % 3 == 0); pick_scan(); cyc();
      end
      chk("pool_full", {4'd0, o_mask}, 8'h0F);

      // Let shots climb and retire off the top edge
      run_until(360);
      chk("slot0_retired", {7'd0, o_mask[0]}, 8'd0);

      // Drop play mid-flight with a fire edge pending
      game = 1'b0; fire = 1'b1; hit_v = 1'b0; pick_scan(); cyc();
      chk("flush_mask", {4'd0, o_mask}, 8'd0);
      chk("flush_draw", {7'd0, o_draw}, 8'd0);
      chk("flush_fired", {7'd0, o_fired}, 8'd0);

      // Hit and fire in the same cycle: hit slot stays busy, new shot goes to slot 2
      game = 1'b1; fire = 1'b0; quiet(); cyc();
      fire_now();
      run_until(12); fire_now();
      run_until(23);
      hit_v = 1'b1; hit_slot = 2'd1; fire = 1'b1; pick_scan(); cyc();
      hit_v = 1'b0; fire = 1'b0;
      chk("hitfire_mask", {4'd0, o_mask}, 8'h05);
      hit_v = 1'b1; hit_slot = 2'd3; pick_scan(); cyc(); hit_v = 1'b0;
      chk("hit_free_mask", {4'd0, o_mask}, 8'h05);

      // Reset mid-flight with a fire edge
      rst_n = 1'b0; fire = 1'b1; pick_scan(); cyc();
      chk("rst_flight_mask", {4'd0, o_mask}, 8'd0);
      chk("rst_flight_fired", {7'd0, o_fired}, 8'd0);
      rst_n = 1'b1; quiet(); cyc();

      // Two shots spawned inside one tick window share a cell; slot 0 wins the draw
      quiet(); cyc();
      fire_now();
      run_until(12); fire_now();
      run_until(20); hit_v = 1'b1; hit_slot = 2'd0; pick_scan(); cyc(); hit_v = 1'b0;
      run_until(24); fire_now();
      run_until(35); fire_now();
      quiet(); scan_row = 6'd28; scan_col = 6'd12; cyc();
      chk("overlap_draw", {7'd0, o_draw}, 8'd1);
      chk("overlap_slot", {6'd0, o_slot}, 8'd0);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         rst_n    = ($urandom_range(0, 499) != 0);
         game     = ($urandom_range(0, 199) != 0);
         fire     = ($urandom_range(0, 3) == 0);
         hit_v    = ($urandom_range(0, 7) == 0);
         hit_slot = 2'($urandom);
         if ($urandom_range(0, 15) == 0) py = 6'($urandom);
         pick_scan();
         cyc();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/shot_sched.md
# shot_sched

Projectile scheduler for the meteorite shooter. Owns a fixed pool of shot slots launched from the player paddle, and decides when a fire request is accepted and which slot it takes. Advances every live shot one board row toward row 0 at a fixed rate and retires shots on the top edge or on a hit. Produces a registered per-cell draw signal for the VGA compositor, alongside the paddle draw.

## Interface
- c_NumShots, 4: shot slots in the pool (2..8).
- c_PaddleRow, 29: board row the paddle is drawn on; shots spawn one row above.
- c_PaddleHeight, 4: paddle span in columns; spawn column = i_PaddleY + c_PaddleHeight/2.
- c_ShotSpeed, 625000: clocks per shot-move tick (25 ms at 25 MHz).
- c_Cooldown, 2500000: clocks after an accepted fire before the next is accepted.
- i_Clk  in  1  system clock.
- i_Rst_L  in  1  synchronous, active-low reset.
- i_Game_Active  in  1  high while play runs; low flushes all shots.
- i_Fire  in  1  fire button, already synchronized.
- i_PaddleY  in  6  current paddle column origin.
- i_Hit_Valid  in  1  one-cycle hit report from collision logic.
- i_Hit_Slot  in  $clog2(c_NumShots)  slot that hit.
- i_ColCountDiv  in  6  current board column being scanned.
- i_RowCountDiv  in  6  current board row being scanned.
- o_DrawShot  out  1  scanned cell holds a live shot.
- o_ShotSlot  out  $clog2(c_NumShots)  lowest-index slot matching the scanned cell.
- o_Fired  out  1  one-cycle pulse per accepted fire.
- o_ActiveMask  out  c_NumShots  per-slot live flags.

## Operation
- Controller FSM:
  - IDLE: entered on reset or when i_Game_Active=0. All slots are cleared. Cooldown and tick counters are held at 0.
  - IDLE→ARMED: on i_Game_Active=1.
  - ARMED→COOLDOWN: on an accepted fire. Cooldown counter loads c_Cooldown-1.
  - COOLDOWN: the counter decrements once per clock. COOLDOWN→ARMED on the cycle the counter equals 0.
  - Any state→IDLE: whenever i_Game_Active=0. This takes priority over everything else.
- Fire acceptance requires all of the following in the same cycle:
  - state ARMED;
  - a fire event: rising edge of i_Fire, i.e. i_Fire=1 and the registered previous sample=0;
  - at least one free slot.
- A fire event that is not accepted is dropped, not queued.
- Allocation: the lowest-index free slot, judged on the slot state at the start of the cycle.
  - The new slot's row is c_PaddleRow-1 and its column is i_PaddleY + c_PaddleHeight/2, computed as 6-bit unsigned.
- Move tick: a free-running counter counts 0..c_ShotSpeed-1 while not IDLE and pulses at its terminal value. On a tick, every live slot that is not being retired:
  - retires if its row is 0;
  - otherwise its row decrements by 1.
- Hit: when i_Hit_Valid=1 and the named slot is live, that slot retires. A hit naming a free slot is ignored.
- Precedence within a slot, per cycle: flush > hit retire > tick move. Allocation applies only to slots that were free at the start of the cycle.
- Simultaneous events:
  - A fire on a tick cycle spawns the new shot unmoved.
  - A hit and a fire in the same cycle: the hit slot is not reusable until the next cycle.
- Draw: o_DrawShot=1 when any live slot has row==i_RowCountDiv and col==i_ColCountDiv. o_ShotSlot is the lowest such index, and 0 when there is no match.

## Timing
- Reset (i_Rst_L=0 at a clock edge) sets:
  - FSM=IDLE;
  - all slots free;
  - counters and fire history = 0;
  - o_DrawShot=0, o_ShotSlot=0, o_Fired=0, o_ActiveMask=0.
- Reset mid-flight discards all shots with no residual pulse.
- Fire latency: for a fire event sampled at edge N, the slot is written at edge N. o_Fired and the updated o_ActiveMask are visible after edge N.
- Draw latency: one clock from the i_RowCountDiv/i_ColCountDiv inputs to o_DrawShot/o_ShotSlot, matching the paddle draw path.
- Maximum fire rate: one shot per c_Cooldown+1 clocks.

## Configuration
- SHOT_AUTOFIRE_EN defined: the fire event is the level i_Fire=1. Holding the button refires on the first ARMED cycle after each cooldown.
- SHOT_AUTOFIRE_EN undefined: the fire event is the rising edge only. Holding the button fires once.

## Structure
- Package shot_pkg holds:
  - c_NumShots default and a slot-index typedef;
  - shot_t struct {active, row[5:0], col[5:0]};
  - the FSM state enum (IDLE, ARMED, COOLDOWN).
- Sub-module shot_slot_alloc: combinational lowest-set-bit priority encoder over the free mask. Outputs a valid flag and an index, and is reused for the o_ShotSlot draw match.

## Test plan
- Reset, then i_Game_Active=1, c_Cooldown=10, i_PaddleY=10, one i_Fire pulse → o_Fired once, slot 0 live at row 28 col 12, o_ActiveMask=4'b0001.
- Fire edges every 3 clocks with c_Cooldown=10 → only edges ≥11 clocks apart are accepted. Five accepted edges with no hits → the fifth is dropped and the mask stays 4'b1111.
- c_ShotSpeed=4, one shot at row 28 → row decrements every 4 clocks. After the row-0 tick, slot 0 is freed.
- i_Hit_Valid with i_Hit_Slot=1 plus a fire edge in the same cycle while slots 0–1 are live → slot 1 retires and the new shot takes slot 2. A hit on a free slot leaves the mask unchanged.
- Scan (row 28, col 12) with slots 0 and 2 both there → o_DrawShot=1 and o_ShotSlot=0, one clock later.
- Drop i_Game_Active mid-flight, and separately pull i_Rst_L low → next cycle the mask is 0, o_DrawShot=0 and no o_Fired occurs. With SHOT_AUTOFIRE_EN defined, i_Fire held → shots every c_Cooldown+1 clocks.
